// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_DONE     = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic sign;
        logic parity;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH steps.
// done is high for exactly one cycle once all steps are complete; reset aborts.
module alu_shift_add_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic              w_done;

    assign w_done  = r_busy && (r_cnt == LAST);
    assign busy    = r_busy;
    assign done    = w_done;
    assign product = r_acc;

    // Control: busy flag and step counter; only these need reset for an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (w_done) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Datapath: load operands on start, then add shifted multiplicand per set bit.
    always_ff @(posedge clk) begin
        if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy && !w_done) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops complete in
// one clock; MUL runs through the shift-add multiplier. Results and flags are
// held in output registers until the sink takes them.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             parity,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam int M   = WIDTH - 1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WIDTH-1:0]  r_out;
    logic [WIDTH-1:0]  r_out_hi;
    flags_t            r_flags;

    op_e               w_op;
    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_dif;
    logic [SHW-1:0]    w_shamt;
    logic [WIDTH-1:0]  w_res;
    logic              w_carry;
    logic              w_ovf;
    logic              w_mul_hi_nz;

    function automatic flags_t make_flags(input logic [WIDTH-1:0] res,
                                          input logic c, input logic v);
        flags_t f;
        f.zero     = (res == '0);
        f.carry    = c;
        f.sign     = res[WIDTH-1];
        f.parity   = ^res;
        f.overflow = v;
        return f;
    endfunction

    assign w_op        = op_e'(op);
    assign in_ready    = !reset && ((r_state == S_IDLE) ||
                                    ((r_state == S_DONE) && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (w_op == OP_MUL);
    assign w_sum       = {1'b0, a} + {1'b0, b};
    assign w_dif       = {1'b0, a} - {1'b0, b};
    assign w_shamt     = b[SHW-1:0];
    assign w_mul_hi_nz = (w_product[2*WIDTH-1:WIDTH] != '0);

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Single-cycle datapath: result plus the op-specific carry/overflow.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[M] == b[M]) && (w_sum[M] != a[M]);
            end
            OP_SUB: begin
                w_res   = w_dif[WIDTH-1:0];
                w_carry = w_dif[WIDTH];
                w_ovf   = (a[M] != b[M]) && (w_dif[M] != a[M]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_SHL:  w_res = a << w_shamt;
            OP_SHR:  w_res = a >> w_shamt;
            default: w_res = '0;
        endcase
    end

    // Next-state logic; an accept in DONE behaves exactly like one in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = (w_op == OP_MUL) ? S_MUL_BUSY : S_DONE;
            end
            S_MUL_BUSY: begin
                if (w_mul_busy && w_mul_done)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_accept)
                    w_state_nxt = (w_op == OP_MUL) ? S_MUL_BUSY : S_DONE;
                else if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Result/flag registers: load on single-cycle accept or on multiplier completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= '0;
            r_out_hi <= '0;
            r_flags  <= '0;
        end else if (w_accept && (w_op != OP_MUL)) begin
            r_out    <= w_res;
            r_out_hi <= '0;
            r_flags  <= make_flags(w_res, w_carry, w_ovf);
        end else if ((r_state == S_MUL_BUSY) && w_mul_done) begin
            r_out    <= w_product[WIDTH-1:0];
            r_out_hi <= w_product[2*WIDTH-1:WIDTH];
            r_flags  <= make_flags(w_product[WIDTH-1:0], w_mul_hi_nz, w_mul_hi_nz);
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign out_hi    = r_out_hi;
    assign zero      = r_flags.zero;
    assign carry     = r_flags.carry;
    assign sign      = r_flags.sign;
    assign parity    = r_flags.parity;
    assign overflow  = r_flags.overflow;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=4 with hand-computed expectations.
module tb_seq_alu;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         zero, carry, sign, parity, overflow;

    int n_chk = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .zero      (zero),
        .carry     (carry),
        .sign      (sign),
        .parity    (parity),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // flags packed as {zero,carry,sign,parity,overflow}
    function automatic logic [4:0] flg();
        return {zero, carry, sign, parity, overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        in_valid = 1'b1;
        op = o;
        a  = av;
        b  = bv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [2:0]   s_op  [7];
    logic [W-1:0] s_a   [7];
    logic [W-1:0] s_b   [7];
    logic [W-1:0] s_exp [7];

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_hi", out_hi, 0);
        chk("rst_flags", flg(), 0);
        chk("rst_inready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("idle_inready", in_ready, 1);

        // ADD 7+1: signed overflow into sign bit
        issue(3'd0, 4'b0111, 4'b0001);
        chk("add1_valid", out_valid, 1);
        chk("add1_out", out, 4'b1000);
        chk("add1_flags", flg(), 5'b00111);
        drain();
        chk("add1_idle", out_valid, 0);

        // ADD F+1: wraps to zero with carry
        issue(3'd0, 4'b1111, 4'b0001);
        chk("add2_out", out, 4'b0000);
        chk("add2_flags", flg(), 5'b11000);
        drain();

        // SUB 3-5: borrow, negative
        issue(3'd1, 4'b0011, 4'b0101);
        chk("sub_out", out, 4'b1110);
        chk("sub_flags", flg(), 5'b01110);
        drain();

        // MUL 13*11 = 143 = 0x8F, with a competing ADD held during busy
        issue(3'd7, 4'd13, 4'd11);
        in_valid = 1'b1; op = 3'd0; a = 4'd1; b = 4'd1;
        for (int k = 0; k < 4; k++) begin
            chk("mul_busy_inready", in_ready, 0);
            chk("mul_busy_valid", out_valid, 0);
            tick();
        end
        chk("mul_e4_valid", out_valid, 0);
        tick();
        chk("mul_valid", out_valid, 1);
        chk("mul_out", out, 4'b1111);
        chk("mul_hi", out_hi, 4'b1000);
        chk("mul_flags", flg(), 5'b01101);

        // Backpressure: 3 clocks with out_ready low and ADD still offered
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_inready", in_ready, 0);
            chk("bp_out", out, 4'b1111);
            chk("bp_hi", out_hi, 4'b1000);
            chk("bp_flags", flg(), 5'b01101);
        end
        in_valid = 1'b0;
        drain();
        chk("bp_idle", out_valid, 0);

        // Back-to-back stream, one result per clock
        s_op[0] = 3'd4; s_a[0] = 4'b0101; s_b[0] = 4'b0011; s_exp[0] = 4'b0110;
        s_op[1] = 3'd5; s_a[1] = 4'b0011; s_b[1] = 4'b0010; s_exp[1] = 4'b1100;
        s_op[2] = 3'd6; s_a[2] = 4'b1000; s_b[2] = 4'b0001; s_exp[2] = 4'b0100;
        s_op[3] = 3'd2; s_a[3] = 4'b1100; s_b[3] = 4'b1010; s_exp[3] = 4'b1000;
        s_op[4] = 3'd3; s_a[4] = 4'b0101; s_b[4] = 4'b0010; s_exp[4] = 4'b0111;
        s_op[5] = 3'd5; s_a[5] = 4'b0011; s_b[5] = 4'b0100; s_exp[5] = 4'b0011;
        s_op[6] = 3'd6; s_a[6] = 4'b1010; s_b[6] = 4'b0000; s_exp[6] = 4'b1010;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            op = s_op[i]; a = s_a[i]; b = s_b[i];
            tick();
            chk($sformatf("b2b%0d_valid", i), out_valid, 1);
            chk($sformatf("b2b%0d_out", i), out, s_exp[i]);
            chk($sformatf("b2b%0d_carry", i), {carry, overflow}, 2'b00);
            chk($sformatf("b2b%0d_parity", i), parity, ^s_exp[i]);
            chk($sformatf("b2b%0d_inready", i), in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", out_valid, 0);

        // Reset two clocks into a MUL
        issue(3'd7, 4'd3, 4'd5);
        tick();
        reset = 1'b1;
        tick();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_out", out, 0);
        chk("mrst_hi", out_hi, 0);
        chk("mrst_flags", flg(), 0);
        chk("mrst_inready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("mrst_idle", in_ready, 1);
        issue(3'd0, 4'd2, 4'd2);
        chk("post_add_valid", out_valid, 1);
        chk("post_add_out", out, 4'b0100);
        chk("post_add_hi", out_hi, 0);
        drain();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_abort_quiet", out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
